// File: rtl/stream_out_framer_if.sv
// Stream bundle between the stream_io serial output, the framer and the host/DMA side.
// The input half has no backpressure; the output half is a valid/ready stream with a frame-end flag.
interface stream_out_framer_if #(
  parameter int DATA_WIDTH = 16
);
  logic                    inV;
  logic [2*DATA_WIDTH-1:0] inData;
  logic                    mValid;
  logic                    mReady;
  logic [2*DATA_WIDTH-1:0] mData;
  logic                    mLast;

  modport master (
    output inV, inData, mReady,
    input  mValid, mData, mLast
  );

  modport slave (
    input  inV, inData, mReady,
    output mValid, mData, mLast
  );
endinterface

// File: rtl/stream_out_framer.sv
// Buffers I/Q words from a non-backpressured source, tags every PE_NUM-th word as frame end,
// and presents them as a valid/ready stream with drop reporting and a delivered-frame counter.
module stream_out_framer #(
  parameter int DATA_WIDTH = 16,
  parameter int PE_NUM     = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  stream_out_framer_if.slave          bus,
  input  logic                        clrOvf_i,
  output logic [$clog2(FIFO_DEPTH):0] level_o,
  output logic                        overflow_o,
  output logic [15:0]                 frameCnt_o
);

  localparam int WW = 2 * DATA_WIDTH;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int BW = $clog2(PE_NUM);

  typedef struct packed {
    logic [WW-1:0] data;
    logic          last;
  } entry_t;

  entry_t        mem [FIFO_DEPTH];
  entry_t        head_q, head_d;
  logic          headValid_q, headValid_d;
  logic [AW-1:0] wrPtr_q, wrPtr_d;
  logic [AW-1:0] rdPtr_q, rdPtr_d;
  logic [LW-1:0] level_q, level_d;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic          overflow_q, overflow_d;
  logic [15:0]   frameCnt_q, frameCnt_d;

  logic   pop;
  logic   push;
  logic   ramEmpty;
  logic   memWrite;
  entry_t inEntry;

  // level includes the head register, so the RAM holds level minus the head's occupancy.
  always_comb begin
    pop        = headValid_q & bus.mReady;
    push       = bus.inV & ((level_q < LW'(FIFO_DEPTH)) | pop);
    ramEmpty   = (level_q == {{(LW-1){1'b0}}, headValid_q});
    inEntry    = '{data: bus.inData, last: (bcnt_q == BW'(PE_NUM - 1))};

    head_d      = head_q;
    headValid_d = headValid_q;
    wrPtr_d     = wrPtr_q;
    rdPtr_d     = rdPtr_q;
    level_d     = level_q;
    bcnt_d      = bcnt_q;
    overflow_d  = overflow_q;
    frameCnt_d  = frameCnt_q;
    memWrite    = 1'b0;

    // The beat counter follows upstream even for dropped words, keeping frame alignment.
    if (bus.inV) begin
      bcnt_d = (bcnt_q == BW'(PE_NUM - 1)) ? '0 : bcnt_q + 1'b1;
    end

    if (bus.inV & ~push) begin
      overflow_d = 1'b1;
    end else if (clrOvf_i) begin
      overflow_d = 1'b0;
    end

    if (pop & head_q.last) begin
      frameCnt_d = frameCnt_q + 1'b1;
    end

    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase

    // Refill the head from RAM first; bypass the RAM only when it has nothing older.
    if (pop | ~headValid_q) begin
      if (!ramEmpty) begin
        head_d      = mem[rdPtr_q];
        headValid_d = 1'b1;
        rdPtr_d     = rdPtr_q + 1'b1;
        memWrite    = push;
      end else if (push) begin
        head_d      = inEntry;
        headValid_d = 1'b1;
      end else begin
        headValid_d = 1'b0;
      end
    end else begin
      memWrite = push;
    end

    if (memWrite) begin
      wrPtr_d = wrPtr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q      <= '0;
      headValid_q <= 1'b0;
      wrPtr_q     <= '0;
      rdPtr_q     <= '0;
      level_q     <= '0;
      bcnt_q      <= '0;
      overflow_q  <= 1'b0;
      frameCnt_q  <= '0;
    end else begin
      head_q      <= head_d;
      headValid_q <= headValid_d;
      wrPtr_q     <= wrPtr_d;
      rdPtr_q     <= rdPtr_d;
      level_q     <= level_d;
      bcnt_q      <= bcnt_d;
      overflow_q  <= overflow_d;
      frameCnt_q  <= frameCnt_d;
    end
  end

  // Storage is intentionally left unreset.
  always_ff @(posedge clk) begin
    if (memWrite) begin
      mem[wrPtr_q] <= inEntry;
    end
  end

  assign bus.mValid = headValid_q;
  assign bus.mData  = head_q.data;
  assign bus.mLast  = head_q.last;
  assign level_o    = level_q;
  assign overflow_o = overflow_q;
  assign frameCnt_o = frameCnt_q;

endmodule

// File: tb/tb_stream_out_framer.sv
// Self-checking bench for stream_out_framer: directed table, corner-case sequences and
// randomized traffic compared against a queue-based reference model.
module tb_stream_out_framer;

  localparam int DW    = 16;
  localparam int PE    = 8;
  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clrOvf;
  logic [4:0]  level;
  logic        overflow;
  logic [15:0] frameCnt;

  int nChecks = 0;
  int nFail   = 0;

  typedef struct packed {
    logic [31:0] d;
    logic        l;
  } word_t;

  word_t mq[$];
  int    mBcnt;
  bit    mOvf;
  int    mFrames;

  typedef struct {
    bit          inV;
    logic [31:0] data;
    bit          ready;
    bit          expValid;
    logic [31:0] expData;
    bit          expLast;
    int          expLevel;
    int          expFrames;
  } vec_t;

  always #5 clk = ~clk;

  stream_out_framer_if #(.DATA_WIDTH(DW)) bus ();

  stream_out_framer #(
    .DATA_WIDTH(DW),
    .PE_NUM    (PE),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .clrOvf_i  (clrOvf),
    .level_o   (level),
    .overflow_o(overflow),
    .frameCnt_o(frameCnt)
  );

  task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    mq.delete();
    mBcnt   = 0;
    mOvf    = 1'b0;
    mFrames = 0;
  endtask

  // One clock of the behavioural rules: pop, then conditional push, drop flag, beat count.
  task automatic modelStep(input bit v, input logic [31:0] d, input bit r, input bit c);
    bit pop;
    bit push;
    pop  = (mq.size() > 0) && r;
    push = v && ((mq.size() < DEPTH) || pop);
    if (pop) begin
      if (mq[0].l) mFrames = (mFrames + 1) % 65536;
      void'(mq.pop_front());
    end
    if (push) mq.push_back('{d: d, l: (mBcnt == PE - 1)});
    if (v && !push) mOvf = 1'b1;
    else if (c)     mOvf = 1'b0;
    if (v) mBcnt = (mBcnt + 1) % PE;
  endtask

  task automatic checkOutput();
    checkValue("m_valid", 32'(bus.mValid), 32'(mq.size() > 0));
    checkValue("level", 32'(level), 32'(mq.size()));
    checkValue("overflow", 32'(overflow), 32'(mOvf));
    checkValue("frame_cnt", 32'(frameCnt), 32'(mFrames));
    if (mq.size() > 0) begin
      checkValue("m_data", bus.mData, mq[0].d);
      checkValue("m_last", 32'(bus.mLast), 32'(mq[0].l));
    end
  endtask

  task automatic applyStimulus(input bit v, input logic [31:0] d, input bit r, input bit c);
    bus.inV    = v;
    bus.inData = d;
    bus.mReady = r;
    clrOvf     = c;
    @(posedge clk);
    modelStep(v, d, r, c);
    #1;
    checkOutput();
  endtask

  task automatic resetDut();
    @(negedge clk);
    bus.inV = 1'b0;
    clrOvf  = 1'b0;
    rst_n   = 1'b0;
    modelReset();
    #1;
    checkValue("rst_valid", 32'(bus.mValid), 32'd0);
    checkValue("rst_level", 32'(level), 32'd0);
    checkValue("rst_frames", 32'(frameCnt), 32'd0);
    checkValue("rst_ovf", 32'(overflow), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic drainAll(input string name);
    for (int k = 0; k < 100 && mq.size() > 0; k++) applyStimulus(1'b0, 32'd0, 1'b1, 1'b0);
    checkValue(name, 32'(bus.mValid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t tbl[9];
    int   sent;

    for (int i = 0; i < 8; i++) begin
      tbl[i] = '{inV: 1'b1, data: 32'(i + 1), ready: 1'b1, expValid: 1'b1,
                 expData: 32'(i + 1), expLast: (i == 7), expLevel: 1, expFrames: 0};
    end
    tbl[8] = '{inV: 1'b0, data: 32'd0, ready: 1'b1, expValid: 1'b0,
               expData: 32'd0, expLast: 1'b0, expLevel: 0, expFrames: 1};

    rst_n      = 1'b0;
    bus.inV    = 1'b0;
    bus.inData = '0;
    bus.mReady = 1'b0;
    clrOvf     = 1'b0;
    modelReset();
    #2;
    checkValue("init_valid", 32'(bus.mValid), 32'd0);
    checkValue("init_last", 32'(bus.mLast), 32'd0);
    checkValue("init_data", bus.mData, 32'd0);
    checkValue("init_level", 32'(level), 32'd0);
    #10;
    rst_n = 1'b1;

    // Words 1..8 with ready held high, one word per cycle, last only on word 8.
    $display("[TB] directed frame table");
    foreach (tbl[i]) begin
      applyStimulus(tbl[i].inV, tbl[i].data, tbl[i].ready, 1'b0);
      checkValue("t1_valid", 32'(bus.mValid), 32'(tbl[i].expValid));
      checkValue("t1_level", 32'(level), 32'(tbl[i].expLevel));
      checkValue("t1_frames", 32'(frameCnt), 32'(tbl[i].expFrames));
      if (tbl[i].expValid) begin
        checkValue("t1_data", bus.mData, tbl[i].expData);
        checkValue("t1_last", 32'(bus.mLast), 32'(tbl[i].expLast));
      end
    end

    $display("[TB] overfill with stalled output");
    resetDut();
    for (int i = 1; i <= 20; i++) applyStimulus(1'b1, 32'h200 + 32'(i), 1'b0, 1'b0);
    checkValue("t2_level", 32'(level), 32'd16);
    checkValue("t2_ovf", 32'(overflow), 32'd1);
    drainAll("t2_drained");
    checkValue("t2_frames", 32'(frameCnt), 32'd2);

    $display("[TB] push and pop on a full FIFO");
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b1);
    checkValue("t3_ovf_clr", 32'(overflow), 32'd0);
    for (int i = 1; i <= 16; i++) applyStimulus(1'b1, 32'h300 + 32'(i), 1'b0, 1'b0);
    checkValue("t3_full", 32'(level), 32'd16);
    applyStimulus(1'b1, 32'h3ff, 1'b1, 1'b0);
    checkValue("t3_level", 32'(level), 32'd16);
    checkValue("t3_ovf", 32'(overflow), 32'd0);
    drainAll("t3_drained");

    $display("[TB] random ready traffic");
    resetDut();
    sent = 0;
    for (int k = 0; k < 2000 && sent < 64; k++) begin
      bit v;
      v = ($urandom_range(0, 1) == 1) && (mq.size() < 12);
      applyStimulus(v, v ? $urandom : 32'd0, $urandom_range(0, 1) == 1, 1'b0);
      if (v) sent++;
    end
    checkValue("t4_sent", 32'(sent), 32'd64);
    drainAll("t4_drained");
    checkValue("t4_frames", 32'(frameCnt), 32'd8);
    checkValue("t4_ovf", 32'(overflow), 32'd0);

    $display("[TB] drop inside a frame");
    resetDut();
    for (int i = 1; i <= 16; i++) applyStimulus(1'b1, 32'h500 + 32'(i), 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h511, 1'b1, 1'b0);
    applyStimulus(1'b1, 32'h512, 1'b1, 1'b0);
    applyStimulus(1'b1, 32'h513, 1'b0, 1'b0);
    checkValue("t5_ovf", 32'(overflow), 32'd1);
    for (int i = 20; i <= 24; i++) applyStimulus(1'b1, 32'h500 + 32'(i), 1'b1, 1'b0);
    drainAll("t5_drained");
    checkValue("t5_frames", 32'(frameCnt), 32'd3);
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b1);
    checkValue("t5_ovf_clr", 32'(overflow), 32'd0);

    $display("[TB] reset mid-burst");
    for (int i = 1; i <= 8; i++) applyStimulus(1'b1, 32'h600 + 32'(i), 1'b1, 1'b0);
    drainAll("t6_pre_drained");
    for (int i = 1; i <= 5; i++) applyStimulus(1'b1, 32'h610 + 32'(i), 1'b0, 1'b0);
    checkValue("t6_level5", 32'(level), 32'd5);
    #3;
    rst_n = 1'b0;
    #1;
    checkValue("t6_valid", 32'(bus.mValid), 32'd0);
    checkValue("t6_level", 32'(level), 32'd0);
    checkValue("t6_frames", 32'(frameCnt), 32'd0);
    modelReset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 1; i <= 8; i++) applyStimulus(1'b1, 32'h620 + 32'(i), 1'b1, 1'b0);
    drainAll("t6_drained");
    checkValue("t6_frames_after", 32'(frameCnt), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", nChecks, nFail);
    $finish;
  end

endmodule
